redmule_x_buffer_fifo: RTL and testbench

//  Parametrised multi-block X operand buffer feeding the RedMulE datapath. Accepts X rows from the

---
 rtl/redmule_x_buffer_fifo.sv | 163 ++++++++++++++++
 tb/tb_redmule_x_buffer_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/redmule_x_buffer_fifo.sv
// rtl/redmule_x_buffer_fifo.sv - multi-tile X operand buffer FIFO for the RedMulE PE array
//
// Purpose: collects X rows from the streamer into Width x Height tiles, zero-pads the
// leftover rows/columns, keeps up to NBLK committed tiles in a circular FIFO and presents
// the head tile to the PE array until it is popped.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         synchronous clear of pointers, counters and storage
//   in_data_i       one row beat, element h at [h*BITW +: BITW]
//   in_valid_i      row beat valid
//   in_ready_o      row beat accepted when valid & ready
//   rows_lftovr_i   valid rows in the tile being started (0 means Width)
//   cols_lftovr_i   valid elements per row in the tile being started (0 means Height)
//   x_buffer_o      head tile (slot at the read pointer)
//   out_valid_o     head tile holds committed data
//   pop_i           consumer releases the head tile
//   count_o         committed tiles stored
//   full_o, empty_o count == NBLK / count == 0
module redmule_x_buffer_fifo #(
    parameter int unsigned BITW   = 16,
    parameter int unsigned Height = 4,
    parameter int unsigned Width  = 4,
    parameter int unsigned NBLK   = 2,
    localparam int unsigned RW    = $clog2(Width) + 1,
    localparam int unsigned CW    = $clog2(Height) + 1,
    localparam int unsigned CNTW  = $clog2(NBLK) + 1,
    localparam int unsigned PW    = $clog2(NBLK)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     clear_i,
    input  logic [Height*BITW-1:0]                   in_data_i,
    input  logic                                     in_valid_i,
    output logic                                     in_ready_o,
    input  logic [RW-1:0]                            rows_lftovr_i,
    input  logic [CW-1:0]                            cols_lftovr_i,
    output logic [Width-1:0][Height-1:0][BITW-1:0]   x_buffer_o,
    output logic                                     out_valid_o,
    input  logic                                     pop_i,
    output logic [CNTW-1:0]                          count_o,
    output logic                                     full_o,
    output logic                                     empty_o
);

    logic [NBLK-1:0][Width-1:0][Height-1:0][BITW-1:0] mem;

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [RW-1:0]   row_idx;
    logic [RW-1:0]   w_lim;
    logic [CW-1:0]   c_lim;
    logic [CNTW-1:0] count;

    logic                          accept;
    logic                          pop;
    logic                          commit;
    logic [RW-1:0]                 eff_w;
    logic [CW-1:0]                 eff_c;
    logic [Height-1:0][BITW-1:0]   row_masked;

    // Explicit wrap compare so non-power-of-2 depths never address a missing slot.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NBLK - 1)) ? '0 : p + PW'(1);
    endfunction

    assign in_ready_o  = (count < CNTW'(NBLK));
    assign out_valid_o = (count != '0);
    assign full_o      = (count == CNTW'(NBLK));
    assign empty_o     = (count == '0);
    assign count_o     = count;

    assign accept = in_valid_i & in_ready_o;
    assign pop    = pop_i & out_valid_o;

    // The leftover sizes only matter on the first beat of a tile; later beats of the same
    // tile use the limits latched on that first beat.
    always_comb begin
        eff_w = w_lim;
        eff_c = c_lim;
        if (row_idx == '0) begin
            eff_w = (rows_lftovr_i == '0) ? RW'(Width)  : rows_lftovr_i;
            eff_c = (cols_lftovr_i == '0) ? CW'(Height) : cols_lftovr_i;
        end
    end

    always_comb begin
        row_masked = '0;
        for (int h = 0; h < Height; h++) begin
            if (CW'(h) < eff_c) begin
                row_masked[h] = in_data_i[h*BITW +: BITW];
            end
        end
    end

    assign commit = accept && (row_idx == eff_w - RW'(1));

    // Head tile is a combinational select of registered storage.
    always_comb begin
        x_buffer_o = '0;
        for (int s = 0; s < NBLK; s++) begin
            if (PW'(s) == rd_ptr) begin
                x_buffer_o = mem[s];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            row_idx <= '0;
            w_lim   <= '0;
            c_lim   <= '0;
            count   <= '0;
        end else if (clear_i) begin
            mem     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            row_idx <= '0;
            w_lim   <= '0;
            c_lim   <= '0;
            count   <= '0;
        end else begin
            if (accept) begin
                // First beat of a tile wipes the whole slot so unused rows read as zero.
                for (int s = 0; s < NBLK; s++) begin
                    for (int w = 0; w < Width; w++) begin
                        if (PW'(s) == wr_ptr) begin
                            if (RW'(w) == row_idx) begin
                                mem[s][w] <= row_masked;
                            end else if (row_idx == '0) begin
                                mem[s][w] <= '0;
                            end
                        end
                    end
                end
                if (row_idx == '0) begin
                    w_lim <= eff_w;
                    c_lim <= eff_c;
                end
                if (commit) begin
                    row_idx <= '0;
                    wr_ptr  <= ptr_inc(wr_ptr);
                end else begin
                    row_idx <= row_idx + RW'(1);
                end
            end

            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end

            if (commit && !pop) begin
                count <= count + CNTW'(1);
            end else if (!commit && pop) begin
                count <= count - CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_redmule_x_buffer_fifo.sv
// tb/tb_redmule_x_buffer_fifo.sv - self-checking bench for redmule_x_buffer_fifo
module tb_redmule_x_buffer_fifo;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT 1: NBLK=2, W=H=4
    logic                    clear1, valid1, pop1, ready1, ov1, full1, empty1;
    logic [63:0]             data1;
    logic [2:0]              rl1, cl1;
    logic [3:0][3:0][15:0]   xbuf1;
    logic [1:0]              cnt1;

    // DUT 2: NBLK=3, W=H=4
    logic                    clear2, valid2, pop2, ready2, ov2, full2, empty2;
    logic [63:0]             data2;
    logic [2:0]              rl2, cl2;
    logic [3:0][3:0][15:0]   xbuf2;
    logic [2:0]              cnt2;

    redmule_x_buffer_fifo #(.BITW(16), .Height(4), .Width(4), .NBLK(2)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear1),
        .in_data_i(data1), .in_valid_i(valid1), .in_ready_o(ready1),
        .rows_lftovr_i(rl1), .cols_lftovr_i(cl1),
        .x_buffer_o(xbuf1), .out_valid_o(ov1), .pop_i(pop1),
        .count_o(cnt1), .full_o(full1), .empty_o(empty1)
    );

    redmule_x_buffer_fifo #(.BITW(16), .Height(4), .Width(4), .NBLK(3)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear2),
        .in_data_i(data2), .in_valid_i(valid2), .in_ready_o(ready2),
        .rows_lftovr_i(rl2), .cols_lftovr_i(cl2),
        .x_buffer_o(xbuf2), .out_valid_o(ov2), .pop_i(pop2),
        .count_o(cnt2), .full_o(full2), .empty_o(empty2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int t, input int r);
        logic [15:0] b;
        b = 16'(t * 256 + r * 16);
        return {b + 16'd3, b + 16'd2, b + 16'd1, b};
    endfunction

    function automatic logic [255:0] full_tile(input int t);
        return {pat(t, 3), pat(t, 2), pat(t, 1), pat(t, 0)};
    endfunction

    typedef struct {
        logic         v;
        logic [63:0]  d;
        logic [2:0]   rl;
        logic [2:0]   cl;
        logic         pop;
        logic         clr;
        logic [1:0]   cnt;
        logic         rdy;
        logic         ov;
        logic [255:0] tile;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic [63:0] d, input logic [2:0] rl,
                                input logic [2:0] cl, input logic pop, input logic clr,
                                input logic [1:0] cnt, input logic rdy, input logic ov,
                                input logic [255:0] tile);
        vec_t x;
        x.v = v; x.d = d; x.rl = rl; x.cl = cl; x.pop = pop; x.clr = clr;
        x.cnt = cnt; x.rdy = rdy; x.ov = ov; x.tile = tile;
        return x;
    endfunction

    task automatic check1(input string nm, input logic [1:0] cnt, input logic rdy,
                          input logic ov, input logic [255:0] tile);
        chk({nm, "_cnt"},   256'(cnt1),   256'(cnt));
        chk({nm, "_rdy"},   256'(ready1), 256'(rdy));
        chk({nm, "_ov"},    256'(ov1),    256'(ov));
        chk({nm, "_full"},  256'(full1),  256'(cnt == 2'd2));
        chk({nm, "_empty"}, 256'(empty1), 256'(cnt == 2'd0));
        chk({nm, "_tile"},  xbuf1,        tile);
    endtask

    task automatic beat1(input logic [63:0] d);
        valid1 = 1'b1; data1 = d; rl1 = '0; cl1 = '0;
        @(posedge clk); #1;
        @(negedge clk);
        valid1 = 1'b0;
    endtask

    task automatic push2(input int t);
        for (int r = 0; r < 4; r++) begin
            int guard;
            valid2 = 1'b1; data2 = pat(t, r); rl2 = '0; cl2 = '0;
            guard = 0;
            while (!ready2 && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (!ready2) begin
                checks++; errors++;
                $display("FAIL push2_ready_timeout: got 0 expected 1");
            end
            @(negedge clk);
        end
        valid2 = 1'b0;
    endtask

    task automatic popchk2(input int t);
        chk($sformatf("pop2_t%0d_ov", t),   256'(ov2), 256'(1));
        chk($sformatf("pop2_t%0d_tile", t), xbuf2,     full_tile(t));
        pop2 = 1'b1;
        @(negedge clk);
        pop2 = 1'b0;
    endtask

    localparam logic [63:0] D3C = 64'h3C00_3C00_3C00_3C00;
    localparam logic [63:0] M3C = 64'h0000_0000_3C00_3C00;

    initial begin
        clear1 = 0; valid1 = 0; pop1 = 0; data1 = '0; rl1 = '0; cl1 = '0;
        clear2 = 0; valid2 = 0; pop2 = 0; data2 = '0; rl2 = '0; cl2 = '0;

        // basic tile, then pop
        vecs.push_back(mk(1, pat(1,0), 0, 0, 0, 0, 0, 1, 0, {192'h0, pat(1,0)}));
        vecs.push_back(mk(1, pat(1,1), 0, 0, 0, 0, 0, 1, 0, {128'h0, pat(1,1), pat(1,0)}));
        vecs.push_back(mk(1, pat(1,2), 0, 0, 0, 0, 0, 1, 0, {64'h0, pat(1,2), pat(1,1), pat(1,0)}));
        vecs.push_back(mk(1, pat(1,3), 0, 0, 0, 0, 1, 1, 1, full_tile(1)));
        vecs.push_back(mk(0, 64'h0,    0, 0, 1, 0, 0, 1, 0, 256'h0));
        // leftover rows/cols; later-beat lftovr values must be ignored
        vecs.push_back(mk(1, D3C, 3, 2, 0, 0, 0, 1, 0, {192'h0, M3C}));
        vecs.push_back(mk(1, D3C, 1, 1, 0, 0, 0, 1, 0, {128'h0, M3C, M3C}));
        vecs.push_back(mk(1, D3C, 1, 1, 0, 0, 1, 1, 1, {64'h0, M3C, M3C, M3C}));
        vecs.push_back(mk(0, 64'h0, 0, 0, 1, 0, 0, 1, 0, full_tile(1)));
        // fill two tiles -> full
        vecs.push_back(mk(1, pat(2,0), 0, 0, 0, 0, 0, 1, 0, {192'h0, pat(2,0)}));
        vecs.push_back(mk(1, pat(2,1), 0, 0, 0, 0, 0, 1, 0, {128'h0, pat(2,1), pat(2,0)}));
        vecs.push_back(mk(1, pat(2,2), 0, 0, 0, 0, 0, 1, 0, {64'h0, pat(2,2), pat(2,1), pat(2,0)}));
        vecs.push_back(mk(1, pat(2,3), 0, 0, 0, 0, 1, 1, 1, full_tile(2)));
        vecs.push_back(mk(1, pat(3,0), 0, 0, 0, 0, 1, 1, 1, full_tile(2)));
        vecs.push_back(mk(1, pat(3,1), 0, 0, 0, 0, 1, 1, 1, full_tile(2)));
        vecs.push_back(mk(1, pat(3,2), 0, 0, 0, 0, 1, 1, 1, full_tile(2)));
        vecs.push_back(mk(1, pat(3,3), 0, 0, 0, 0, 2, 0, 1, full_tile(2)));
        // stalled beat, pop frees slot, beat accepted the cycle after
        vecs.push_back(mk(1, pat(4,0), 0, 0, 0, 0, 2, 0, 1, full_tile(2)));
        vecs.push_back(mk(1, pat(4,0), 0, 0, 1, 0, 1, 1, 1, full_tile(3)));
        vecs.push_back(mk(1, pat(4,0), 0, 0, 0, 0, 1, 1, 1, full_tile(3)));
        vecs.push_back(mk(1, pat(4,1), 0, 0, 0, 0, 1, 1, 1, full_tile(3)));
        vecs.push_back(mk(1, pat(4,2), 0, 0, 0, 0, 1, 1, 1, full_tile(3)));
        // commit and pop together with count=1
        vecs.push_back(mk(1, pat(4,3), 0, 0, 1, 0, 1, 1, 1, full_tile(4)));
        // clear mid-tile wins over beat and pop
        vecs.push_back(mk(0, 64'h0,    0, 0, 1, 0, 0, 1, 0, full_tile(3)));
        vecs.push_back(mk(1, pat(5,0), 0, 0, 0, 0, 0, 1, 0, {192'h0, pat(5,0)}));
        vecs.push_back(mk(1, pat(5,1), 0, 0, 0, 0, 0, 1, 0, {128'h0, pat(5,1), pat(5,0)}));
        vecs.push_back(mk(1, pat(5,2), 0, 0, 1, 1, 0, 1, 0, 256'h0));
        vecs.push_back(mk(1, pat(6,0), 0, 0, 0, 0, 0, 1, 0, {192'h0, pat(6,0)}));
        vecs.push_back(mk(1, pat(6,1), 0, 0, 0, 0, 0, 1, 0, {128'h0, pat(6,1), pat(6,0)}));
        vecs.push_back(mk(1, pat(6,2), 0, 0, 0, 0, 0, 1, 0, {64'h0, pat(6,2), pat(6,1), pat(6,0)}));
        vecs.push_back(mk(1, pat(6,3), 0, 0, 0, 0, 1, 1, 1, full_tile(6)));
        vecs.push_back(mk(0, 64'h0,    0, 0, 1, 0, 0, 1, 0, 256'h0));

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check1("reset", 2'd0, 1'b1, 1'b0, 256'h0);
        chk("reset2_cnt",   256'(cnt2),   256'(0));
        chk("reset2_rdy",   256'(ready2), 256'(1));
        chk("reset2_empty", 256'(empty2), 256'(1));
        @(negedge clk);

        foreach (vecs[i]) begin
            valid1 = vecs[i].v;  data1 = vecs[i].d;
            rl1 = vecs[i].rl;    cl1 = vecs[i].cl;
            pop1 = vecs[i].pop;  clear1 = vecs[i].clr;
            @(posedge clk); #1;
            check1($sformatf("v%0d", i), vecs[i].cnt, vecs[i].rdy, vecs[i].ov, vecs[i].tile);
            @(negedge clk);
        end
        valid1 = 0; pop1 = 0; clear1 = 0;

        // async reset mid-tile discards the partial tile
        beat1(pat(7,0));
        beat1(pat(7,1));
        #2 rst_n = 1'b0;
        #1;
        check1("areset", 2'd0, 1'b1, 1'b0, 256'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) beat1(pat(8, r));
        check1("after_areset", 2'd1, 1'b1, 1'b1, full_tile(8));

        // NBLK=3: FIFO order across pointer wrap
        push2(10); push2(11); push2(12);
        chk("n3_full",  256'(full2),  256'(1));
        chk("n3_cnt3",  256'(cnt2),   256'(3));
        chk("n3_rdy0",  256'(ready2), 256'(0));
        popchk2(10);
        push2(13);
        popchk2(11);
        popchk2(12);
        push2(14); push2(15);
        popchk2(13);
        push2(16);
        popchk2(14);
        popchk2(15);
        popchk2(16);
        chk("n3_empty", 256'(empty2), 256'(1));
        chk("n3_cnt0",  256'(cnt2),   256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
